// File: rtl/corelet_pkg.sv
// Shared types and constants for the corelet tile sequencer.
// Latency: n/a (types, constants and a helper function only).
// Backpressure: n/a.
package corelet_pkg;

    typedef enum logic [2:0] {
        IDLE,
        W_FILL,
        W_LOAD,
        EXEC,
        DRAIN,
        DONE
    } state_t;

    // {execute, kernel_load} instruction word driven into the corelet
    localparam logic [1:0] INST_IDLE  = 2'b00;
    localparam logic [1:0] INST_KLOAD = 2'b01;
    localparam logic [1:0] INST_EXEC  = 2'b10;

    function automatic int max2(input int a, input int b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/sram_l0_feeder.sv
// Streams n consecutive xmem reads from base into L0, one per cycle.
// Latency: read issued combinationally; l0_wr follows one cycle later (xmem read latency).
// Backpressure: no new read while l0_full; a read already in flight still lands in L0's slack entry.
//
// Ports:
//   clk, reset          clock, sync active-high reset
//   active              enables issuing; counters clear whenever low
//   l0_full             L0 cannot accept another write
//   base, n             first xmem address and number of reads for this pass
//   xmem_cen, xmem_addr xmem read request (cen active low)
//   l0_wr               L0 write strobe, registered copy of the previous cycle's read
//   wr_cnt              L0 writes completed in this pass
//   last_wr             l0_wr for the final word of the pass
module sram_l0_feeder
    import corelet_pkg::*;
#(
    parameter int addr_w = 11,
    parameter int cnt_w  = 6
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              active,
    input  logic              l0_full,
    input  logic [addr_w-1:0] base,
    input  logic [cnt_w-1:0]  n,
    output logic              xmem_cen,
    output logic [addr_w-1:0] xmem_addr,
    output logic              l0_wr,
    output logic [cnt_w-1:0]  wr_cnt,
    output logic              last_wr
);

    logic [cnt_w-1:0] rd_cnt;
    logic             issue;

    // rd_cnt saturates at n, so no read is issued past the end of the pass.
    // The address tracks rd_cnt, so it holds on its own while l0_full stalls.
    assign issue     = active && !l0_full && (rd_cnt < n);
    assign xmem_cen  = !issue;
    assign xmem_addr = active ? (base + addr_w'(rd_cnt)) : '0;
    assign last_wr   = l0_wr && (wr_cnt == (n - 1'b1));

    always_ff @(posedge clk) begin
        if (reset || !active) begin
            rd_cnt <= '0;
            wr_cnt <= '0;
            l0_wr  <= 1'b0;
        end else begin
            l0_wr <= issue;
            if (issue) begin
                rd_cnt <= rd_cnt + 1'b1;
            end
            if (l0_wr) begin
                wr_cnt <= wr_cnt + 1'b1;
            end
        end
    end

endmodule

// File: rtl/corelet_seq_ctrl.sv
// Weight-stationary tile sequencer: per kij fill L0 with weights, kernel-load, execute, drain OFIFO to pmem.
// Latency: W_FILL col+1, W_LOAD col+row, EXEC n_act+2 (unstalled), DRAIN n_act+1 with ofifo_valid held high.
// Backpressure: l0_full stalls new xmem reads; an empty L0 pauses pops; ofifo_valid gates each drain pop.
//
// Ports:
//   clk, reset                     clock, sync active-high reset
//   start                          begins a tile from IDLE only
//   l0_full, ofifo_valid           corelet status
//   inst, l0_wr, l0_rd, ofifo_rd   corelet control
//   xmem_cen/wen/addr              activation/weight SRAM (read only)
//   pmem_cen/wen/addr              psum SRAM write port, registered
//   busy, done                     tile status
module corelet_seq_ctrl
    import corelet_pkg::*;
#(
    parameter int row     = 8,
    parameter int col     = 8,
    parameter int n_act   = 36,
    parameter int n_kij   = 9,
    parameter int xaddr_w = 11,
    parameter int paddr_w = 11,
    parameter int w_base  = 0,
    parameter int a_base  = 1024
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               start,
    input  logic               l0_full,
    input  logic               ofifo_valid,
    output logic [1:0]         inst,
    output logic               l0_wr,
    output logic               l0_rd,
    output logic               ofifo_rd,
    output logic               xmem_cen,
    output logic               xmem_wen,
    output logic [xaddr_w-1:0] xmem_addr,
    output logic               pmem_cen,
    output logic               pmem_wen,
    output logic [paddr_w-1:0] pmem_addr,
    output logic               busy,
    output logic               done
);

    localparam int CNT_W = $clog2(max2(n_act, col + row) + 1);
    localparam int KIJ_W = $clog2(n_kij + 1);

    localparam logic [CNT_W-1:0]   COL_C     = CNT_W'(col);
    localparam logic [CNT_W-1:0]   N_ACT_C   = CNT_W'(n_act);
    localparam logic [CNT_W-1:0]   LOAD_LAST = CNT_W'(col + row - 1);
    localparam logic [KIJ_W-1:0]   KIJ_LAST  = KIJ_W'(n_kij - 1);
    localparam logic [xaddr_w-1:0] A_BASE_C  = xaddr_w'(a_base);

    state_t             state;
    state_t             state_nxt;
    logic [KIJ_W-1:0]   kij;
    // Shared phase counter: cycles in W_LOAD, L0 pops in EXEC, OFIFO pops in DRAIN.
    logic [CNT_W-1:0]   cnt;
    logic               cnt_inc;

    logic               fd_active;
    logic [xaddr_w-1:0] fd_base;
    logic [CNT_W-1:0]   fd_n;
    logic [CNT_W-1:0]   fd_wr_cnt;
    logic               fd_last_wr;
    logic [xaddr_w-1:0] w_addr_base;

    assign w_addr_base = xaddr_w'(w_base) + xaddr_w'(kij) * xaddr_w'(col);
    assign fd_active   = (state == W_FILL) || (state == EXEC);
    assign fd_base     = (state == EXEC) ? A_BASE_C : w_addr_base;
    assign fd_n        = (state == EXEC) ? N_ACT_C : COL_C;
    assign xmem_wen    = 1'b1;

    sram_l0_feeder #(
        .addr_w (xaddr_w),
        .cnt_w  (CNT_W)
    ) u_feeder (
        .clk       (clk),
        .reset     (reset),
        .active    (fd_active),
        .l0_full   (l0_full),
        .base      (fd_base),
        .n         (fd_n),
        .xmem_cen  (xmem_cen),
        .xmem_addr (xmem_addr),
        .l0_wr     (l0_wr),
        .wr_cnt    (fd_wr_cnt),
        .last_wr   (fd_last_wr)
    );

    always_comb begin
        state_nxt = state;
        inst      = INST_IDLE;
        l0_rd     = 1'b0;
        ofifo_rd  = 1'b0;
        cnt_inc   = 1'b0;
        busy      = 1'b1;
        done      = 1'b0;
        case (state)
            IDLE: begin
                busy = 1'b0;
                if (start) begin
                    state_nxt = W_FILL;
                end
            end
            W_FILL: begin
                if (fd_last_wr) begin
                    state_nxt = W_LOAD;
                end
            end
            W_LOAD: begin
                inst    = INST_KLOAD;
                // Weights leave L0 in the first col cycles; the rest lets them settle through the rows.
                l0_rd   = (cnt < COL_C);
                cnt_inc = (cnt != LOAD_LAST);
                if (cnt == LOAD_LAST) begin
                    state_nxt = EXEC;
                end
            end
            EXEC: begin
                inst = INST_EXEC;
                // Pop only words already written, so L0 can never underflow.
                l0_rd   = (cnt < fd_wr_cnt) && (cnt < N_ACT_C);
                cnt_inc = l0_rd;
                if (l0_rd && (cnt == N_ACT_C - 1'b1)) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                ofifo_rd = ofifo_valid && (cnt < N_ACT_C);
                cnt_inc  = ofifo_rd;
                // Leave only once the last registered pmem write is on the bus.
                if ((cnt == N_ACT_C) && !pmem_cen) begin
                    state_nxt = (kij < KIJ_LAST) ? W_FILL : DONE;
                end
            end
            DONE: begin
                busy      = 1'b0;
                done      = 1'b1;
                state_nxt = IDLE;
            end
            default: begin
                busy      = 1'b0;
                state_nxt = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            kij       <= '0;
            cnt       <= '0;
            pmem_cen  <= 1'b1;
            pmem_wen  <= 1'b1;
            pmem_addr <= '0;
        end else begin
            state <= state_nxt;
            if ((state == IDLE) && start) begin
                kij <= '0;
            end else if ((state == DRAIN) && (state_nxt == W_FILL)) begin
                kij <= kij + 1'b1;
            end
            if (state_nxt != state) begin
                cnt <= '0;
            end else if (cnt_inc) begin
                cnt <= cnt + 1'b1;
            end
            // Each OFIFO pop becomes a pmem write on the following cycle.
            pmem_cen <= !ofifo_rd;
            pmem_wen <= !ofifo_rd;
            if (ofifo_rd) begin
                pmem_addr <= paddr_w'(kij) * paddr_w'(n_act) + paddr_w'(cnt);
            end
        end
    end

endmodule

// File: tb/tb_corelet_seq_ctrl.sv
module tb_corelet_seq_ctrl;

    localparam int ROW    = 8;
    localparam int COL    = 8;
    localparam int N_ACT  = 4;
    localparam int N_KIJ  = 2;
    localparam int XW     = 11;
    localparam int PW     = 11;
    localparam int W_BASE = 0;
    localparam int A_BASE = 1024;

    logic          clk;
    logic          reset;
    logic          start;
    logic          l0_full;
    logic          ofifo_valid;
    logic [1:0]    inst;
    logic          l0_wr;
    logic          l0_rd;
    logic          ofifo_rd;
    logic          xmem_cen;
    logic          xmem_wen;
    logic [XW-1:0] xmem_addr;
    logic          pmem_cen;
    logic          pmem_wen;
    logic [PW-1:0] pmem_addr;
    logic          busy;
    logic          done;

    corelet_seq_ctrl #(
        .row(ROW), .col(COL), .n_act(N_ACT), .n_kij(N_KIJ),
        .xaddr_w(XW), .paddr_w(PW), .w_base(W_BASE), .a_base(A_BASE)
    ) dut (
        .clk(clk), .reset(reset), .start(start), .l0_full(l0_full),
        .ofifo_valid(ofifo_valid), .inst(inst), .l0_wr(l0_wr), .l0_rd(l0_rd),
        .ofifo_rd(ofifo_rd), .xmem_cen(xmem_cen), .xmem_wen(xmem_wen),
        .xmem_addr(xmem_addr), .pmem_cen(pmem_cen), .pmem_wen(pmem_wen),
        .pmem_addr(pmem_addr), .busy(busy), .done(done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk = 0;
    int n_fail = 0;
    int cyc = 0;

    int xq[$];
    int pq[$];
    int exp_x[$];
    int exp_p[$];
    int runq[$];

    int n_rd, n_wr, n_pop, n_done, tiles, occ, under;
    int pops01, pops10, rd_bad, phase_bad, wen_bad, inst11, run01;
    int full_wr, max_full_wr, rd_full, hold_bad, orphan, mirror_bad, busy_bad;
    int t_start, first01, dpops, stall_left;
    int st_at1, st_len1, st_at2, st_len2;
    bit st_fired1, st_fired2;
    bit was_full, prev_pop, prev_busy, in_drain;
    bit start_nxt, auto_start, wl_pulsed;
    int ofifo_mode;
    logic [1:0]    prev_inst;
    logic [XW-1:0] held;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        n_chk++;
        assert (obs === expv) else begin
            n_fail++;
            $error("FAIL %s: observed %0d expected %0d", tag, obs, expv);
        end
    endtask

    task automatic clear_obs();
        xq.delete(); pq.delete(); runq.delete();
        n_rd = 0; n_wr = 0; n_pop = 0; n_done = 0; tiles = 0; occ = 0; under = 0;
        pops01 = 0; pops10 = 0; rd_bad = 0; phase_bad = 0; wen_bad = 0; inst11 = 0; run01 = 0;
        full_wr = 0; max_full_wr = 0; rd_full = 0; hold_bad = 0; orphan = 0;
        mirror_bad = 0; busy_bad = 0; t_start = -1; first01 = -1; dpops = 0;
        stall_left = 0; st_at1 = -1; st_at2 = -1; st_len1 = 0; st_len2 = 0;
        st_fired1 = 0; st_fired2 = 0; was_full = 0; prev_pop = 0; prev_busy = 0;
        in_drain = 0; start_nxt = 0; auto_start = 0; wl_pulsed = 0; ofifo_mode = 0;
        prev_inst = 2'b00; held = '0;
    endtask

    // Per-cycle observation: builds event logs and invariant counters from the pins.
    task automatic sample();
        logic exp_rd;
        if (xmem_cen === 1'b0) begin
            xq.push_back(int'(xmem_addr));
            n_rd++;
            if ((int'(xmem_addr) >= A_BASE) != (inst === 2'b10)) phase_bad++;
        end
        if (xmem_wen !== 1'b1) wen_bad++;
        if (inst === 2'b11) inst11++;
        if (inst === 2'b01) run01++;
        else if (run01 != 0) begin
            runq.push_back(run01);
            run01 = 0;
        end
        if (l0_rd === 1'b1) begin
            if (inst === 2'b01) pops01++;
            else if (inst === 2'b10) pops10++;
            else rd_bad++;
            if (occ == 0) under++;
            else occ--;
        end
        if (l0_wr === 1'b1) begin
            occ++;
            n_wr++;
        end
        if (l0_full === 1'b1) begin
            if (l0_wr === 1'b1) full_wr++;
            if (full_wr > max_full_wr) max_full_wr = full_wr;
            if (xmem_cen !== 1'b1) rd_full++;
            if (was_full && xmem_addr !== held) hold_bad++;
            held = xmem_addr;
            was_full = 1;
        end else begin
            if (was_full && xmem_addr !== held) hold_bad++;
            full_wr = 0;
            was_full = 0;
        end
        if (pmem_cen === 1'b0) begin
            pq.push_back(int'(pmem_addr));
            if (pmem_wen !== 1'b0) wen_bad++;
            if (!prev_pop) orphan++;
        end else if (pmem_wen !== 1'b1) wen_bad++;
        if (busy === 1'b1 && inst === 2'b00 && prev_inst === 2'b10) begin
            in_drain = 1;
            dpops = 0;
        end
        if (!(busy === 1'b1 && inst === 2'b00)) in_drain = 0;
        exp_rd = in_drain && (ofifo_valid === 1'b1) && (dpops < N_ACT);
        if (ofifo_rd !== exp_rd) mirror_bad++;
        if (ofifo_rd === 1'b1) begin
            dpops++;
            n_pop++;
        end
        if (done === 1'b1) begin
            n_done++;
            if (busy !== 1'b0) busy_bad++;
        end
        if (busy === 1'b1 && !prev_busy) begin
            tiles++;
            if (t_start < 0) t_start = cyc;
        end
        if (inst === 2'b01 && first01 < 0) first01 = cyc;
        prev_pop  = (ofifo_rd === 1'b1);
        prev_busy = (busy === 1'b1);
        prev_inst = inst;
    endtask

    task automatic cycle();
        @(negedge clk);
        start = start_nxt;
        start_nxt = 0;
        if (stall_left > 0) begin
            l0_full = 1'b1;
            stall_left--;
        end else l0_full = 1'b0;
        case (ofifo_mode)
            0:       ofifo_valid = 1'b1;
            1:       ofifo_valid = ~ofifo_valid;
            default: ofifo_valid = 1'($urandom_range(0, 1));
        endcase
        #1;
        sample();
        cyc++;
        if (st_at1 >= 0 && !st_fired1 && n_rd == st_at1) begin
            st_fired1 = 1;
            stall_left = st_len1;
        end
        if (st_at2 >= 0 && !st_fired2 && n_rd == st_at2) begin
            st_fired2 = 1;
            stall_left = st_len2;
        end
        // Late-cycle start pulses, seen by the DUT at the edge closing this cycle.
        if (auto_start && ((inst === 2'b01 && !wl_pulsed) || done === 1'b1)) begin
            start = 1'b1;
            if (inst === 2'b01) wl_pulsed = 1;
        end
    endtask

    task automatic run_tile(input int idle_after);
        start_nxt = 1;
        for (int i = 0; i < 3000; i++) begin
            cycle();
            if (n_done > 0) break;
        end
        for (int i = 0; i < idle_after; i++) cycle();
    endtask

    task automatic check_idle(input string tag);
        chk({tag, "_inst"}, 32'(inst), 0);
        chk({tag, "_l0_wr"}, 32'(l0_wr), 0);
        chk({tag, "_l0_rd"}, 32'(l0_rd), 0);
        chk({tag, "_ofifo_rd"}, 32'(ofifo_rd), 0);
        chk({tag, "_xmem_cen"}, 32'(xmem_cen), 1);
        chk({tag, "_xmem_wen"}, 32'(xmem_wen), 1);
        chk({tag, "_xmem_addr"}, 32'(xmem_addr), 0);
        chk({tag, "_pmem_cen"}, 32'(pmem_cen), 1);
        chk({tag, "_pmem_wen"}, 32'(pmem_wen), 1);
        chk({tag, "_pmem_addr"}, 32'(pmem_addr), 0);
        chk({tag, "_busy"}, 32'(busy), 0);
        chk({tag, "_done"}, 32'(done), 0);
    endtask

    // Checks common to every completed tile, against the address lists and counts from the model.
    task automatic check_tile(input string tag);
        chk({tag, "_xreads"}, xq.size(), exp_x.size());
        for (int i = 0; i < xq.size() && i < exp_x.size(); i++)
            chk({tag, "_xaddr"}, xq[i], exp_x[i]);
        chk({tag, "_pwrites"}, pq.size(), exp_p.size());
        for (int i = 0; i < pq.size() && i < exp_p.size(); i++)
            chk({tag, "_paddr"}, pq[i], exp_p[i]);
        chk({tag, "_done_pulses"}, n_done, 1);
        chk({tag, "_l0_writes"}, n_wr, N_KIJ * (COL + N_ACT));
        chk({tag, "_kload_pops"}, pops01, N_KIJ * COL);
        chk({tag, "_exec_pops"}, pops10, N_KIJ * N_ACT);
        chk({tag, "_ofifo_pops"}, n_pop, N_KIJ * N_ACT);
        chk({tag, "_l0_underflow"}, under, 0);
        chk({tag, "_pop_in_idle_inst"}, rd_bad, 0);
        chk({tag, "_read_phase"}, phase_bad, 0);
        chk({tag, "_wen"}, wen_bad, 0);
        chk({tag, "_inst11"}, inst11, 0);
        chk({tag, "_ofifo_mirror"}, mirror_bad, 0);
        chk({tag, "_orphan_write"}, orphan, 0);
        chk({tag, "_busy_at_done"}, busy_bad, 0);
        chk({tag, "_tiles"}, tiles, 1);
        chk({tag, "_kload_runs"}, runq.size(), N_KIJ);
        foreach (runq[i]) chk({tag, "_kload_len"}, runq[i], COL + ROW);
        chk({tag, "_busy_end"}, 32'(busy), 0);
    endtask

    initial begin
        int ex;
        reset = 1'b1;
        start = 1'b0;
        l0_full = 1'b0;
        ofifo_valid = 1'b0;
        for (int k = 0; k < N_KIJ; k++) begin
            for (int i = 0; i < COL; i++) exp_x.push_back(W_BASE + k * COL + i);
            for (int v = 0; v < N_ACT; v++) exp_x.push_back(A_BASE + v);
        end
        for (int k = 0; k < N_KIJ; k++)
            for (int v = 0; v < N_ACT; v++) exp_p.push_back(k * N_ACT + v);

        repeat (3) @(negedge clk);
        #1;
        check_idle("reset");
        reset = 1'b0;
        clear_obs();
        repeat (2) cycle();

        // 1: nominal tile, no stalls, OFIFO always valid
        clear_obs();
        run_tile(5);
        check_tile("nominal");
        chk("nominal_wfill_len", first01 - t_start, COL + 1);
        chk("nominal_full_writes", max_full_wr, 0);

        // 2: l0_full stalls inside W_FILL of both kij passes
        clear_obs();
        st_at1 = $urandom_range(1, 5);
        st_len1 = 5;
        st_at2 = COL + N_ACT + $urandom_range(1, 5);
        st_len2 = $urandom_range(1, 4);
        run_tile(5);
        check_tile("stall");
        chk("stall_read_while_full", rd_full, 0);
        chk("stall_addr_hold", hold_bad, 0);
        chk("stall_inflight_write", max_full_wr, 1);

        // 3: OFIFO valid toggles every cycle
        clear_obs();
        ofifo_mode = 1;
        run_tile(5);
        check_tile("slow_ofifo");

        // 4: reset on the third EXEC cycle, then a fresh tile from kij 0
        clear_obs();
        start_nxt = 1;
        ex = 0;
        for (int i = 0; i < 500 && ex < 3; i++) begin
            cycle();
            if (inst === 2'b10) ex++;
        end
        chk("exec_reached", ex, 3);
        reset = 1'b1;
        @(negedge clk);
        reset = 1'b0;
        l0_full = 1'b0;
        #1;
        check_idle("midreset");
        clear_obs();
        run_tile(5);
        check_tile("after_reset");

        // 5: start pulsed during W_LOAD and DONE, random OFIFO valid
        clear_obs();
        ofifo_mode = 2;
        auto_start = 1;
        run_tile(30);
        check_tile("start_ignored");
        chk("start_ignored_no_reads_after", n_rd, exp_x.size());

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
